// File: rtl/map_tile_arbiter_if.sv
// Bundle for map_tile_arbiter: renderer port, game port, clear control and map RAM bus.
// slave = the arbiter side, master = the environment driving requests and hosting the RAM.
interface map_tile_arbiter_if;
    // renderer read port
    logic       rd_req;
    logic [4:0] rd_row;
    logic [4:0] rd_col;
    logic       rd_gnt;
    logic       rd_valid;
    logic [7:0] rd_data;
    // game / HPS port
    logic       g_valid;
    logic       g_ready;
    logic       g_write;
    logic [4:0] g_row;
    logic [4:0] g_col;
    logic [7:0] g_wdata;
    logic       g_rvalid;
    logic [7:0] g_rdata;
    // level clear
    logic       clear_start;
    logic [7:0] clear_value;
    logic       busy;
    // map RAM
    logic [9:0] ram_address;
    logic       ram_chipselect;
    logic       ram_write;
    logic       ram_debugaccess;
    logic [7:0] ram_writedata;
    logic       ram_clken;
    logic [7:0] ram_readdata;

    modport slave (
        input  rd_req, rd_row, rd_col, g_valid, g_write, g_row, g_col, g_wdata,
               clear_start, clear_value, ram_readdata,
        output rd_gnt, rd_valid, rd_data, g_ready, g_rvalid, g_rdata, busy,
               ram_address, ram_chipselect, ram_write, ram_debugaccess, ram_writedata, ram_clken
    );

    modport master (
        output rd_req, rd_row, rd_col, g_valid, g_write, g_row, g_col, g_wdata,
               clear_start, clear_value, ram_readdata,
        input  rd_gnt, rd_valid, rd_data, g_ready, g_rvalid, g_rdata, busy,
               ram_address, ram_chipselect, ram_write, ram_debugaccess, ram_writedata, ram_clken
    );
endinterface

// File: rtl/map_tile_arbiter.sv
// map_tile_arbiter: shares the single-port 30x30 tile RAM between the renderer and the
// game port, maps (row, col) to linear addresses, answers off-map reads with a wall code
// and sweeps the whole map for a level clear.
// Optional feature: define MAP_TILE_ARB_FAIR_EN to give the game port a guaranteed slot
// after STARVE_LIMIT consecutive render wins; without it the renderer has strict priority.
module map_tile_arbiter #(
    parameter int         MAP_W        = 30,
    parameter int         MAP_H        = 30,
    parameter logic [7:0] OOB_VALUE    = 8'h01,
    parameter int         STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    map_tile_arbiter_if.slave bus
);
    localparam logic [4:0] ROWS      = 5'(MAP_H);
    localparam logic [4:0] COLS      = 5'(MAP_W);
    localparam logic [9:0] LAST_ADDR = 10'(MAP_W * MAP_H - 1);

    typedef enum logic {RUN, CLEAR} state_t;
    state_t state, state_nxt;

    logic [9:0] clr_addr;
    logic [7:0] clr_val;
    logic [9:0] rd_addr, g_addr;
    logic       rd_oob, g_oob;
    logic       rd_gnt, g_ready, g_acc, force_game;
    logic       rd_vld_q, rd_oob_q, g_vld_q, g_oob_q;
    logic [9:0] ram_address;
    logic       ram_we;
    logic [7:0] ram_writedata;

    // row*30 + col without a multiplier: (row<<5) - (row<<1) + col; the shift form fixes MAP_W at 30
    function automatic logic [9:0] tile_addr(input logic [4:0] row, input logic [4:0] col);
        logic [9:0] r;
        r = {5'd0, row};
        return (r << 5) - (r << 1) + {5'd0, col};
    endfunction

    assign rd_addr = tile_addr(bus.rd_row, bus.rd_col);
    assign g_addr  = tile_addr(bus.g_row, bus.g_col);
    assign rd_oob  = (bus.rd_row >= ROWS) || (bus.rd_col >= COLS);
    assign g_oob   = (bus.g_row >= ROWS) || (bus.g_col >= COLS);
    assign g_acc   = g_ready & bus.g_valid;

`ifdef MAP_TILE_ARB_FAIR_EN
    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
    logic [CW-1:0] fair_cnt;

    assign force_game = (fair_cnt == LIMIT);

    // count render wins while the game port waits; any game service or idle game port restarts it
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                       fair_cnt <= '0;
        else if (state != RUN || !bus.g_valid || g_acc)  fair_cnt <= '0;
        else if (rd_gnt)                                 fair_cnt <= fair_cnt + 1'b1;
    end
`else
    assign force_game = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    // next state: sweep starts after clear_start, ends once the last tile is written
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (bus.clear_start)        state_nxt = CLEAR;
            CLEAR:   if (clr_addr == LAST_ADDR)  state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // outputs: grants and the single RAM access of this cycle; nothing here depends on ram_readdata
    always_comb begin
        rd_gnt        = 1'b0;
        g_ready       = 1'b0;
        ram_address   = g_addr;
        ram_we        = 1'b0;
        ram_writedata = bus.g_wdata;
        if (!reset) begin
            if (state == CLEAR) begin
                ram_address   = clr_addr;
                ram_we        = 1'b1;
                ram_writedata = clr_val;
            end else begin
                rd_gnt  = bus.rd_req & ~force_game;
                g_ready = ~bus.rd_req | force_game;
                if (rd_gnt) ram_address = rd_addr;
                // off-map writes are accepted but never reach the RAM
                ram_we = g_acc & bus.g_write & ~g_oob;
            end
        end
    end

    // read-return tracking and clear sweep datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_vld_q <= 1'b0;
            rd_oob_q <= 1'b0;
            g_vld_q  <= 1'b0;
            g_oob_q  <= 1'b0;
            clr_addr <= '0;
            clr_val  <= '0;
        end else begin
            rd_vld_q <= rd_gnt;
            rd_oob_q <= rd_oob;
            g_vld_q  <= g_acc & ~bus.g_write;
            g_oob_q  <= g_oob;
            if (state == RUN && bus.clear_start) begin
                clr_val  <= bus.clear_value;
                clr_addr <= '0;
            end else if (state == CLEAR) begin
                clr_addr <= clr_addr + 10'd1;
            end
        end
    end

    assign bus.rd_gnt          = rd_gnt;
    assign bus.g_ready         = g_ready;
    assign bus.busy            = (state == CLEAR);
    assign bus.ram_address     = ram_address;
    assign bus.ram_chipselect  = ram_we;
    assign bus.ram_write       = ram_we;
    assign bus.ram_debugaccess = ram_we;
    assign bus.ram_writedata   = ram_writedata;
    assign bus.ram_clken       = 1'b1;
    assign bus.rd_valid        = rd_vld_q;
    assign bus.g_rvalid        = g_vld_q;
    // data is held at zero outside a valid cycle so idle outputs stay quiet
    assign bus.rd_data         = !rd_vld_q ? 8'h00 : (rd_oob_q ? OOB_VALUE : bus.ram_readdata);
    assign bus.g_rdata         = !g_vld_q  ? 8'h00 : (g_oob_q  ? OOB_VALUE : bus.ram_readdata);
endmodule

// File: tb/tb_map_tile_arbiter.sv
// Bench for map_tile_arbiter: behavioural RAM plus a shadow map of what every tile should hold.
module tb_map_tile_arbiter;
    localparam int LIMIT = 8;
`ifdef MAP_TILE_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    map_tile_arbiter_if bus();
    map_tile_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .reset(reset), .bus(bus));

    // RAM: registered address, unregistered read data
    logic [7:0] mem [0:1023];
    logic [9:0] addr_q;
    always @(posedge clk) begin
        if (bus.ram_clken) begin
            addr_q <= bus.ram_address;
            if (bus.ram_chipselect && bus.ram_write && bus.ram_debugaccess)
                mem[bus.ram_address] <= bus.ram_writedata;
        end
    end
    assign bus.ram_readdata = mem[addr_q];

    logic [7:0] shadow [0:899];

    function automatic logic [7:0] exp_read(input int r, input int c);
        if (r >= 30 || c >= 30) return 8'h01;
        return shadow[r * 30 + c];
    endfunction

    task automatic idle();
        bus.rd_req = 0; bus.rd_row = 0; bus.rd_col = 0;
        bus.g_valid = 0; bus.g_write = 0; bus.g_row = 0; bus.g_col = 0; bus.g_wdata = 0;
        bus.clear_start = 0; bus.clear_value = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.rd_gnt, bus.g_ready, bus.rd_valid, bus.g_rvalid, bus.busy, bus.ram_chipselect,
             bus.ram_write, bus.ram_debugaccess, bus.ram_clken} !== 9'b000000001) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000001", {bus.rd_gnt, bus.g_ready, bus.rd_valid,
                     bus.g_rvalid, bus.busy, bus.ram_chipselect, bus.ram_write, bus.ram_debugaccess, bus.ram_clken});
        end
        checks++;
        if ({bus.rd_data, bus.g_rdata, bus.ram_address} !== 26'd0) begin
            errors++;
            $display("FAIL reset_data: rd_data %h g_rdata %h addr %0d want 0", bus.rd_data, bus.g_rdata, bus.ram_address);
        end
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bus.g_valid = 1; bus.g_write = 1; bus.g_row = 2; bus.g_col = 3; bus.g_wdata = 8'h5A;
        #1;
        checks++;
        if ({bus.g_ready, bus.ram_write, bus.ram_address, bus.ram_writedata} !== {1'b1, 1'b1, 10'd63, 8'h5A}) begin
            errors++;
            $display("FAIL basic_write: ready %b we %b addr %0d data %h want 1 1 63 5a",
                     bus.g_ready, bus.ram_write, bus.ram_address, bus.ram_writedata);
        end
        shadow[63] = 8'h5A;
        @(negedge clk);
        idle(); bus.rd_req = 1; bus.rd_row = 2; bus.rd_col = 3;
        #1;
        checks++;
        if ({bus.rd_gnt, bus.g_ready, bus.ram_write, bus.ram_address} !== {1'b1, 1'b0, 1'b0, 10'd63}) begin
            errors++;
            $display("FAIL basic_grant: gnt %b ready %b we %b addr %0d want 1 0 0 63",
                     bus.rd_gnt, bus.g_ready, bus.ram_write, bus.ram_address);
        end
        @(negedge clk);
        idle();
        checks++;
        if ({bus.rd_valid, bus.g_rvalid, bus.rd_data} !== {1'b1, 1'b0, 8'h5A}) begin
            errors++;
            $display("FAIL basic_read: rd_valid %b g_rvalid %b data %h want 1 0 5a", bus.rd_valid, bus.g_rvalid, bus.rd_data);
        end
        @(negedge clk);
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_drop: rd_valid %b want 0", bus.rd_valid);
        end
    endtask

    task automatic test_oob();
        logic [7:0] keep;
        keep = exp_read(1, 1);
        bus.rd_req = 1; bus.rd_row = 30; bus.rd_col = 0;
        #1;
        checks++;
        if (bus.rd_gnt !== 1'b1) begin errors++; $display("FAIL oob_rd_gnt: got %b want 1", bus.rd_gnt); end
        @(negedge clk);
        idle();
        checks++;
        if ({bus.rd_valid, bus.rd_data} !== {1'b1, 8'h01}) begin
            errors++; $display("FAIL oob_rd_data: valid %b data %h want 1 01", bus.rd_valid, bus.rd_data);
        end
        bus.g_valid = 1; bus.g_write = 1; bus.g_row = 0; bus.g_col = 31; bus.g_wdata = 8'hFF;
        #1;
        checks++;
        if ({bus.g_ready, bus.ram_write, bus.ram_chipselect} !== 3'b100) begin
            errors++; $display("FAIL oob_write: ready/we/cs %b want 100", {bus.g_ready, bus.ram_write, bus.ram_chipselect});
        end
        @(negedge clk);
        idle(); bus.g_valid = 1; bus.g_row = 31; bus.g_col = 31;
        checks++;
        if (bus.g_rvalid !== 1'b0) begin errors++; $display("FAIL oob_write_rvalid: got %b want 0", bus.g_rvalid); end
        @(negedge clk);
        idle(); bus.g_valid = 1; bus.g_row = 1; bus.g_col = 1;
        checks++;
        if ({bus.g_rvalid, bus.g_rdata} !== {1'b1, 8'h01}) begin
            errors++; $display("FAIL oob_g_read: valid %b data %h want 1 01", bus.g_rvalid, bus.g_rdata);
        end
        @(negedge clk);
        idle();
        checks++;
        if ({bus.g_rvalid, bus.g_rdata} !== {1'b1, keep}) begin
            errors++; $display("FAIL oob_no_alias: valid %b data %h want 1 %h", bus.g_rvalid, bus.g_rdata, keep);
        end
    endtask

    task automatic test_write_then_read();
        for (int k = 0; k < 4; k++) begin
            int r, c;
            logic [7:0] d;
            r = $urandom_range(0, 29); c = $urandom_range(0, 29); d = 8'($urandom);
            idle(); bus.g_valid = 1; bus.g_write = 1; bus.g_row = 5'(r); bus.g_col = 5'(c); bus.g_wdata = d;
            shadow[r * 30 + c] = d;
            @(negedge clk);
            bus.g_write = 0;
            if (k[0]) begin bus.g_valid = 0; bus.rd_req = 1; bus.rd_row = 5'(r); bus.rd_col = 5'(c); end
            @(negedge clk);
            idle();
            checks++;
            if (k[0] ? ({bus.rd_valid, bus.rd_data} !== {1'b1, d}) : ({bus.g_rvalid, bus.g_rdata} !== {1'b1, d})) begin
                errors++;
                $display("FAIL wr_then_rd[%0d]: rd %b/%h g %b/%h want %h", k, bus.rd_valid, bus.rd_data, bus.g_rvalid, bus.g_rdata, d);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int streak = 0;
        bit pend_rd = 0, pend_g = 0;
        logic [7:0] pend_rd_d = 0, pend_g_d = 0;
        for (int cyc = 0; cyc <= 400; cyc++) begin
            int rr, rc, gr, gc;
            bit starved, exp_gnt, exp_rdy, acc, in_map;
            checks++;
            if (bus.rd_valid !== pend_rd || (pend_rd && bus.rd_data !== pend_rd_d)) begin
                errors++; $display("FAIL rand_rd c%0d: %b/%h want %b/%h", cyc, bus.rd_valid, bus.rd_data, pend_rd, pend_rd_d);
            end
            checks++;
            if (bus.g_rvalid !== pend_g || (pend_g && bus.g_rdata !== pend_g_d)) begin
                errors++; $display("FAIL rand_g c%0d: %b/%h want %b/%h", cyc, bus.g_rvalid, bus.g_rdata, pend_g, pend_g_d);
            end
            if (cyc == 400) break;
            rr = ($urandom_range(0, 7) == 0) ? $urandom_range(30, 31) : $urandom_range(0, 29);
            rc = ($urandom_range(0, 7) == 0) ? $urandom_range(30, 31) : $urandom_range(0, 29);
            gr = ($urandom_range(0, 7) == 0) ? $urandom_range(30, 31) : $urandom_range(0, 29);
            gc = ($urandom_range(0, 7) == 0) ? $urandom_range(30, 31) : $urandom_range(0, 29);
            bus.rd_req = ($urandom_range(0, 99) < 60); bus.rd_row = 5'(rr); bus.rd_col = 5'(rc);
            bus.g_valid = $urandom_range(0, 1); bus.g_write = $urandom_range(0, 1);
            bus.g_row = 5'(gr); bus.g_col = 5'(gc); bus.g_wdata = 8'($urandom);
            #1;
            starved = FAIR && (streak == LIMIT);
            exp_gnt = bus.rd_req && !starved;
            exp_rdy = !bus.rd_req || starved;
            acc     = bus.g_valid && exp_rdy;
            in_map  = (gr < 30) && (gc < 30);
            checks++;
            if ({bus.rd_gnt, bus.g_ready} !== {exp_gnt, exp_rdy}) begin
                errors++; $display("FAIL rand_grant c%0d: gnt/rdy %b%b want %b%b", cyc, bus.rd_gnt, bus.g_ready, exp_gnt, exp_rdy);
            end
            checks++;
            if (bus.ram_write !== (acc && bus.g_write && in_map)) begin
                errors++; $display("FAIL rand_we c%0d: got %b want %b", cyc, bus.ram_write, acc && bus.g_write && in_map);
            end
            if (exp_gnt && rr < 30 && rc < 30) begin
                checks++;
                if (bus.ram_address !== 10'(rr * 30 + rc)) begin
                    errors++; $display("FAIL rand_rd_addr c%0d: got %0d want %0d", cyc, bus.ram_address, rr * 30 + rc);
                end
            end
            if (acc && in_map) begin
                checks++;
                if (bus.ram_address !== 10'(gr * 30 + gc)) begin
                    errors++; $display("FAIL rand_g_addr c%0d: got %0d want %0d", cyc, bus.ram_address, gr * 30 + gc);
                end
            end
            pend_rd = exp_gnt;
            pend_rd_d = exp_read(rr, rc);
            pend_g = acc && !bus.g_write;
            pend_g_d = exp_read(gr, gc);
            if (acc && bus.g_write && in_map) shadow[gr * 30 + gc] = bus.g_wdata;
            if (!bus.g_valid || acc) streak = 0;
            else if (exp_gnt) streak++;
            @(negedge clk);
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        bit prev_acc = 0;
        bus.rd_req = 1; bus.rd_row = 4; bus.rd_col = 7;
        bus.g_valid = 1; bus.g_write = 0; bus.g_row = 5; bus.g_col = 5;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            bit want_g;
            checks++;
            if (bus.g_rvalid !== prev_acc || bus.rd_valid !== (cyc > 1 && !prev_acc)) begin
                errors++; $display("FAIL starve_valid c%0d: g %b rd %b want g %b", cyc, bus.g_rvalid, bus.rd_valid, prev_acc);
            end
            #1;
            want_g = FAIR && (cyc % (LIMIT + 1) == 0);
            checks++;
            if ({bus.rd_gnt, bus.g_ready} !== {!want_g, want_g}) begin
                errors++; $display("FAIL starve_grant c%0d: gnt/rdy %b%b want %b%b", cyc, bus.rd_gnt, bus.g_ready, !want_g, want_g);
            end
            if (bus.g_ready) accepts++;
            prev_acc = want_g;
            @(negedge clk);
        end
        checks++;
        if (accepts !== (FAIR ? 2 : 0)) begin
            errors++; $display("FAIL starve_count: got %0d want %0d", accepts, FAIR ? 2 : 0);
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_clear();
        int n = 0;
        logic [7:0] last_old;
        last_old = exp_read(29, 29);
        bus.clear_start = 1; bus.clear_value = 8'h00;
        bus.rd_req = 1; bus.rd_row = 29; bus.rd_col = 29;
        #1;
        checks++;
        if (bus.rd_gnt !== 1'b1) begin errors++; $display("FAIL clear_start_gnt: got %b want 1", bus.rd_gnt); end
        @(negedge clk);
        bus.clear_start = 0; bus.clear_value = 8'h77;
        bus.g_valid = 1; bus.g_write = 1; bus.g_wdata = 8'hEE;
        checks++;
        if ({bus.rd_valid, bus.rd_data} !== {1'b1, last_old}) begin
            errors++; $display("FAIL clear_start_read: %b/%h want 1/%h", bus.rd_valid, bus.rd_data, last_old);
        end
        while (bus.busy === 1'b1 && n < 1000) begin
            checks++;
            if ({bus.ram_address, bus.ram_write, bus.ram_writedata, bus.rd_gnt, bus.g_ready} !== {10'(n), 1'b1, 8'h00, 2'b00}) begin
                errors++; $display("FAIL clear_step n%0d: addr %0d we %b data %h gnt %b rdy %b", n, bus.ram_address,
                                   bus.ram_write, bus.ram_writedata, bus.rd_gnt, bus.g_ready);
            end
            bus.clear_start = (n == 100);
            n++;
            @(negedge clk);
        end
        idle();
        checks++;
        if (n !== 900) begin errors++; $display("FAIL clear_len: got %0d want 900", n); end
        for (int i = 0; i < 900; i++) shadow[i] = 8'h00;
        bus.g_valid = 1; bus.g_row = 29; bus.g_col = 29;
        @(negedge clk);
        idle();
        checks++;
        if ({bus.g_rvalid, bus.g_rdata} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL clear_readback: %b/%h want 1/00", bus.g_rvalid, bus.g_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_clear();
        int n = 0;
        int tiles [6] = '{0, 399, 400, 401, 899, 213};
        bus.clear_start = 1; bus.clear_value = 8'hA5;
        @(negedge clk);
        idle();
        while (!(bus.busy === 1'b1 && bus.ram_address === 10'd400) && n < 1000) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n >= 1000) begin errors++; $display("FAIL midclr_reach: addr 400 not seen, got %0d", bus.ram_address); end
        #1 reset = 1;
        #1;
        checks++;
        if ({bus.busy, bus.ram_write, bus.rd_gnt, bus.g_ready} !== 4'b0000) begin
            errors++; $display("FAIL midclr_abort: busy/we/gnt/rdy %b want 0000", {bus.busy, bus.ram_write, bus.rd_gnt, bus.g_ready});
        end
        for (int i = 0; i < 400; i++) shadow[i] = 8'hA5;
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        foreach (tiles[k]) begin
            int r, c;
            r = tiles[k] / 30; c = tiles[k] % 30;
            idle();
            if (k[0]) begin bus.rd_req = 1; bus.rd_row = 5'(r); bus.rd_col = 5'(c); end
            else begin bus.g_valid = 1; bus.g_row = 5'(r); bus.g_col = 5'(c); end
            #1;
            checks++;
            if ((k[0] ? bus.rd_gnt : bus.g_ready) !== 1'b1 || bus.busy !== 1'b0) begin
                errors++; $display("FAIL midclr_resume t%0d: gnt %b rdy %b busy %b", tiles[k], bus.rd_gnt, bus.g_ready, bus.busy);
            end
            @(negedge clk);
            idle();
            checks++;
            if (k[0] ? ({bus.rd_valid, bus.rd_data} !== {1'b1, exp_read(r, c)})
                     : ({bus.g_rvalid, bus.g_rdata} !== {1'b1, exp_read(r, c)})) begin
                errors++; $display("FAIL midclr_tile t%0d: rd %b/%h g %b/%h want %h", tiles[k], bus.rd_valid, bus.rd_data,
                                   bus.g_rvalid, bus.g_rdata, exp_read(r, c));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        for (int i = 0; i < 900; i++) shadow[i] = 8'h00;
        idle();
        reset = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_oob();
        test_write_then_read();
        test_random();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete, errors so far %0d", errors);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/map_tile_arbiter.md
# map_tile_arbiter

Arbitrates the single-port 30x30 map tile RAM (900 x 8-bit, registered address, unregistered read data) between the VGA sprite renderer and the game-logic/HPS tile port. Converts (row, col) tile coordinates to linear addresses and returns a fixed wall code for off-map coordinates. Also provides a sequenced full-map clear for level reset. Sits between the renderer, the game engine and the map RAM.

## Interface
- MAP_W, 30, tiles per row
- MAP_H, 30, tile rows
- OOB_VALUE, 8'h01, tile code returned for off-map reads (wall)
- STARVE_LIMIT, 8, consecutive render grants before the game port is forced a slot (fairness build only)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rd_req  in  1  renderer read request
- rd_row, rd_col  in  5 each  renderer tile coordinate
- rd_gnt  out  1  renderer request accepted this cycle
- rd_valid  out  1  rd_data valid (cycle after grant)
- rd_data  out  8  renderer tile code
- g_valid  in  1  game request valid
- g_ready  out  1  game request accepted when g_valid & g_ready
- g_write  in  1  1 = write, 0 = read
- g_row, g_col  in  5 each  game tile coordinate
- g_wdata  in  8  write tile code
- g_rvalid  out  1  g_rdata valid (cycle after read accept)
- g_rdata  out  8  game read data
- clear_start  in  1  pulse: fill entire map with clear_value
- clear_value  in  8  fill code, sampled on clear_start
- busy  out  1  clear sweep in progress
- ram_address  out  10  to RAM address
- ram_chipselect, ram_write, ram_debugaccess  out  1 each  RAM write qualifiers (all three high on every write)
- ram_writedata  out  8  RAM write data
- ram_clken  out  1  RAM clock enable, constant 1
- ram_readdata  in  8  RAM read data

## Operation
- States: RUN, CLEAR. Reset -> RUN.
- Address = row*MAP_W + col, computed as (row<<5)-(row<<1)+col, 10 bits, max 899.
- Off-map: row >= MAP_H or col >= MAP_W. Off-map read: granted, no RAM access, returns OOB_VALUE. Off-map write: accepted, dropped (no RAM write).
- RUN, default priority: rd_req wins; rd_gnt = rd_req; g_ready = ~rd_req.
- One RAM access per cycle; grants are exclusive (rd_gnt & g_ready & g_valid never coincide).
- Game write: ram_chipselect/ram_write/ram_debugaccess high for exactly the accept cycle; no g_rvalid.
- clear_start in RUN: latch clear_value, enter CLEAR next cycle. Requests in the clear_start cycle are still served.
- CLEAR: counter 0..899, one write per cycle, rd_gnt=0, g_ready=0, busy=1. After address 899 written, return to RUN (busy low next cycle). clear_start while busy ignored.
- Reset mid-clear: sweep aborted, RAM partially cleared, state RUN.

## Timing
- Reset values: all outputs 0 except ram_clken=1; fairness counter 0.
- Read latency: grant in cycle N -> rd_valid/g_rvalid high in N+1 with data = ram_readdata (passthrough) or OOB_VALUE (registered select).
- Write at cycle N then read same tile at N+1 returns new data.
- Clear duration: exactly 900 cycles of busy; sweep starts the cycle after clear_start.
- g_ready/rd_gnt are combinational from rd_req, state and fairness counter; no combinational path from ram_readdata to any handshake.

## Configuration
- MAP_TILE_ARB_FAIR_EN defined: counter of consecutive render grants while g_valid is high; at STARVE_LIMIT the next cycle grants the game port (g_ready=1, rd_gnt=0 even if rd_req), counter clears. Counter clears whenever g_valid is low or a game request is accepted.
- Undefined: strict render priority; game port may starve indefinitely.

## Test plan
- Render read (row 2, col 3) after writing 8'h5A there via game port -> ram_address 63, rd_valid next cycle, rd_data 8'h5A.
- Render read (row 30, col 0) -> no RAM access, rd_data 8'h01; game write (0, 31) -> g_ready=1, no ram_write pulse.
- rd_req and g_valid held high 20 cycles -> non-fair build: g_ready never high; fair build (STARVE_LIMIT 8): game accepted on cycle 9, render resumes cycle 10.
- clear_start with clear_value 8'h00 -> busy exactly 900 cycles, writes to addresses 0..899 in order, then readback of (29,29) gives 8'h00.
- Assert reset at clear address 400 -> busy drops immediately, tiles >= 400 keep old contents, ports resume after reset release.
- Write then read same tile on consecutive cycles -> g_rvalid in cycle after read with new value.
